// File: rtl/rs_15_11_encoder.sv
// Systematic RS(15,11) encoder over GF(16), x^4+x+1. Forwards 11 message
// symbols, then 4 parity symbols from an LFSR divide by g(x).
// Ports: CLK, RST_N (async, active-low); in_valid/in_ready/sym_in message
// input; out_valid/out_ready/out_sym/out_sop/out_eop codeword output.
module rs_15_11_encoder #(
  parameter int         N_SYM = 15,
  parameter int         K_SYM = 11,
  parameter logic [3:0] G3    = 4'hD,
  parameter logic [3:0] G2    = 4'hC,
  parameter logic [3:0] G1    = 4'h8,
  parameter logic [3:0] G0    = 4'h7
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] sym_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_sym,
  output logic       out_sop,
  output logic       out_eop
);

  typedef enum logic {
    S_MSG    = 1'b0,
    S_PARITY = 1'b1
  } state_t;

  localparam logic [3:0] LastMsg = 4'(K_SYM - 1);
  localparam logic [3:0] LastPar = 4'(N_SYM - K_SYM - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] r3_q, r3_d;
  logic [3:0] r2_q, r2_d;
  logic [3:0] r1_q, r1_d;
  logic [3:0] r0_q, r0_d;
  logic       out_valid_q, out_valid_d;
  logic [3:0] out_sym_q, out_sym_d;
  logic       out_sop_q, out_sop_d;
  logic       out_eop_q, out_eop_d;

  logic       slot_free;
  logic [3:0] fb;

  // GF(16) multiply: shift-and-add, reducing x^4 to x+1.
  function automatic logic [3:0] gf_mul(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [3:0] p;
    logic [3:0] x;
    p = 4'h0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  assign slot_free = !out_valid_q | out_ready;
  assign fb        = sym_in ^ r3_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r3_d        = r3_q;
    r2_d        = r2_q;
    r1_d        = r1_q;
    r0_d        = r0_q;
    out_valid_d = out_valid_q;
    out_sym_d   = out_sym_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    in_ready    = 1'b0;

    case (state_q)
      S_MSG: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          out_sym_d   = sym_in;
          out_valid_d = 1'b1;
          out_sop_d   = (cnt_q == 4'd0);
          out_eop_d   = 1'b0;
          r3_d        = r2_q ^ gf_mul(fb, G3);
          r2_d        = r1_q ^ gf_mul(fb, G2);
          r1_d        = r0_q ^ gf_mul(fb, G1);
          r0_d        = gf_mul(fb, G0);
          if (cnt_q == LastMsg) begin
            cnt_d   = 4'd0;
            state_d = S_PARITY;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (out_valid_q && out_ready) begin
          // Drained with nothing to replace it.
          out_valid_d = 1'b0;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b0;
        end
      end
      S_PARITY: begin
        if (slot_free) begin
          out_sym_d   = r3_q;
          out_valid_d = 1'b1;
          out_sop_d   = 1'b0;
          out_eop_d   = (cnt_q == LastPar);
          r3_d        = r2_q;
          r2_d        = r1_q;
          r1_d        = r0_q;
          r0_d        = 4'h0;
          if (cnt_q == LastPar) begin
            cnt_d   = 4'd0;
            state_d = S_MSG;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_MSG;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_MSG;
      cnt_q       <= 4'd0;
      r3_q        <= 4'h0;
      r2_q        <= 4'h0;
      r1_q        <= 4'h0;
      r0_q        <= 4'h0;
      out_valid_q <= 1'b0;
      out_sym_q   <= 4'h0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r3_q        <= r3_d;
      r2_q        <= r2_d;
      r1_q        <= r1_d;
      r0_q        <= r0_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sym   = out_sym_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;

endmodule

// File: tb/tb_rs_15_11_encoder.sv
// Bench for rs_15_11_encoder: random messages against a polynomial
// long-division reference, syndrome checks, backpressure and reset.
module tb_rs_15_11_encoder;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] sym_in = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_sym;
  logic       out_sop;
  logic       out_eop;

  rs_15_11_encoder dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sym_in   (sym_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sym  (out_sym),
    .out_sop  (out_sop),
    .out_eop  (out_eop)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int low_cnt = 0;
  bit rand_ready = 1'b0;

  typedef struct {
    logic [3:0] sym;
    logic       sop;
    logic       eop;
    int         cyc;
  } rec_t;

  rec_t       act_q[$];
  logic [3:0] exp_q[$];
  logic [3:0] msg[11];
  logic [3:0] ref_cw[15];
  logic [3:0] gexp[15];
  int         glog[16];

  always @(posedge CLK) cyc++;

  always @(posedge CLK) begin
    #1;
    out_ready = rand_ready ? ($urandom % 4 != 0) : 1'b1;
  end

  // Output monitor: record transfers, check held symbols under stall.
  logic [3:0] prev_sym;
  bit         prev_stall = 1'b0;
  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_sym !== prev_sym) begin
          errors++;
          if (errors < 20)
            $display("FAIL stall_hold valid=%b sym=%h required valid=1 sym=%h",
                     out_valid, out_sym, prev_sym);
        end
      end
      if (out_valid && out_ready)
        act_q.push_back('{out_sym, out_sop, out_eop, cyc});
      if (!in_ready) low_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_sym   = out_sym;
    end
  end

  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    if (a == 4'h0 || b == 4'h0) return 4'h0;
    return gexp[(glog[a] + glog[b]) % 15];
  endfunction

  function automatic void build_tables();
    logic [4:0] v;
    v = 5'd1;
    for (int i = 0; i < 15; i++) begin
      gexp[i] = v[3:0];
      glog[v[3:0]] = i;
      v = v << 1;
      if (v[4]) v = v ^ 5'h13;
    end
  endfunction

  // Codeword = msg(x)*x^4 + (msg(x)*x^4 mod g(x)), by long division.
  function automatic void build_ref();
    logic [3:0] a[15];
    logic [3:0] g[5];
    logic [3:0] c;
    g[0] = 4'h1; g[1] = 4'hD; g[2] = 4'hC; g[3] = 4'h8; g[4] = 4'h7;
    for (int i = 0; i < 15; i++) a[i] = (i < 11) ? msg[i] : 4'h0;
    for (int i = 0; i < 11; i++) begin
      c = a[i];
      for (int j = 1; j <= 4; j++) a[i+j] = a[i+j] ^ gmul(c, g[j]);
    end
    for (int i = 0; i < 15; i++) ref_cw[i] = (i < 11) ? msg[i] : a[i];
  endfunction

  function automatic logic [3:0] synd(input int j, input int base);
    logic [3:0] s;
    s = 4'h0;
    for (int i = 0; i < 15; i++) s = gmul(s, gexp[j]) ^ act_q[base+i].sym;
    return s;
  endfunction

  task automatic send_msg(input bit gaps, input int nsym);
    bit acc;
    int t;
    for (int k = 0; k < nsym; k++) begin
      if (gaps) begin
        while ($urandom % 4 == 0) begin
          in_valid = 1'b0;
          @(posedge CLK); #1;
        end
      end
      in_valid = 1'b1;
      sym_in   = msg[k];
      t = 0;
      acc = 1'b0;
      while (!acc && t < 200) begin
        @(negedge CLK);
        acc = in_valid && in_ready;
        @(posedge CLK); #1;
        t++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout symbol=%0d in_ready=%b required 1", k, in_ready);
        return;
      end
    end
  endtask

  task automatic wait_outputs(input int n, input int budget);
    int t;
    t = 0;
    while (act_q.size() < n && t < budget) begin
      @(posedge CLK); #1;
      t++;
    end
    checks++;
    if (act_q.size() < n) begin
      errors++;
      $display("FAIL output_count got %0d required %0d", act_q.size(), n);
    end
  endtask

  task automatic check_cw(input int base, input string name);
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (act_q[base+i].sym !== ref_cw[i] ||
          act_q[base+i].sop !== (i == 0) ||
          act_q[base+i].eop !== (i == 14)) begin
        errors++;
        if (errors < 20)
          $display("FAIL %s sym%0d got %h sop=%b eop=%b required %h sop=%b eop=%b",
                   name, i, act_q[base+i].sym, act_q[base+i].sop,
                   act_q[base+i].eop, ref_cw[i], i == 0, i == 14);
      end
    end
  endtask

  task automatic check_gapfree(input int base, input int n, input string name);
    for (int i = 1; i < n; i++) begin
      checks++;
      if (act_q[base+i].cyc !== act_q[base].cyc + i) begin
        errors++;
        if (errors < 20)
          $display("FAIL %s gap at %0d cycle %0d required %0d", name, i,
                   act_q[base+i].cyc, act_q[base].cyc + i);
      end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({out_valid, out_sym, out_sop, out_eop} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b s=%h sop=%b eop=%b required all 0",
               out_valid, out_sym, out_sop, out_eop);
    end
    RST_N = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_all_zero();
    act_q.delete();
    foreach (msg[i]) msg[i] = 4'h0;
    build_ref();
    send_msg(1'b0, 11);
    in_valid = 1'b0;
    wait_outputs(15, 100);
    if (act_q.size() >= 15) begin
      check_cw(0, "all_zero");
      check_gapfree(0, 15, "all_zero");
    end
  endtask

  task automatic test_last_one();
    logic [3:0] par[4];
    par[0] = 4'hD; par[1] = 4'hC; par[2] = 4'h8; par[3] = 4'h7;
    act_q.delete();
    foreach (msg[i]) msg[i] = (i == 10) ? 4'h1 : 4'h0;
    build_ref();
    send_msg(1'b0, 11);
    in_valid = 1'b0;
    wait_outputs(15, 100);
    if (act_q.size() >= 15) begin
      check_cw(0, "last_one");
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (act_q[11+i].sym !== par[i]) begin
          errors++;
          $display("FAIL last_one_parity%0d got %h required %h", i, act_q[11+i].sym, par[i]);
        end
      end
    end
  endtask

  task automatic test_first_one();
    logic [3:0] s;
    act_q.delete();
    foreach (msg[i]) msg[i] = (i == 0) ? 4'h1 : 4'h0;
    build_ref();
    send_msg(1'b0, 11);
    in_valid = 1'b0;
    wait_outputs(15, 100);
    if (act_q.size() >= 15) begin
      check_cw(0, "first_one");
      for (int j = 1; j <= 4; j++) begin
        s = synd(j, 0);
        checks++;
        if (s !== 4'h0) begin
          errors++;
          $display("FAIL first_one_syndrome S%0d got %h required 0", j, s);
        end
      end
    end
  endtask

  task automatic test_random();
    int nerr;
    act_q.delete();
    exp_q.delete();
    rand_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      foreach (msg[i]) msg[i] = 4'($urandom);
      build_ref();
      foreach (ref_cw[i]) exp_q.push_back(ref_cw[i]);
      send_msg(1'b1, 11);
    end
    in_valid = 1'b0;
    wait_outputs(15000, 2000);
    rand_ready = 1'b0;
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count got %0d required %0d", act_q.size(), exp_q.size());
    end
    nerr = 0;
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i].sym !== exp_q[i] || act_q[i].sop !== (i % 15 == 0) ||
          act_q[i].eop !== (i % 15 == 14)) begin
        errors++;
        nerr++;
        if (nerr < 10)
          $display("FAIL random sym%0d got %h sop=%b eop=%b required %h sop=%b eop=%b",
                   i, act_q[i].sym, act_q[i].sop, act_q[i].eop, exp_q[i],
                   i % 15 == 0, i % 15 == 14);
      end
    end
    for (int b = 0; b + 15 <= act_q.size() && b < 150; b += 15) begin
      for (int j = 1; j <= 4; j++) begin
        checks++;
        if (synd(j, b) !== 4'h0) begin
          errors++;
          $display("FAIL random_syndrome cw%0d S%0d got %h required 0", b / 15, j, synd(j, b));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] cws[45];
    repeat (2) @(posedge CLK);
    #1;
    act_q.delete();
    low_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      foreach (msg[i]) msg[i] = 4'($urandom);
      build_ref();
      foreach (ref_cw[i]) cws[c*15+i] = ref_cw[i];
      send_msg(1'b0, 11);
    end
    in_valid = 1'b0;
    wait_outputs(45, 200);
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (low_cnt != 12) begin
      errors++;
      $display("FAIL b2b_in_ready_low got %0d cycles required 12", low_cnt);
    end
    if (act_q.size() >= 45) begin
      for (int c = 0; c < 3; c++) begin
        foreach (ref_cw[i]) ref_cw[i] = cws[c*15+i];
        check_cw(c * 15, "b2b");
      end
      check_gapfree(0, 45, "b2b");
    end
  endtask

  task automatic test_mid_reset();
    act_q.delete();
    foreach (msg[i]) msg[i] = 4'($urandom);
    send_msg(1'b0, 6);
    in_valid = 1'b0;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_sym, out_sop, out_eop} !== 7'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs got v=%b s=%h sop=%b eop=%b required all 0",
               out_valid, out_sym, out_sop, out_eop);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    act_q.delete();
    foreach (msg[i]) msg[i] = 4'($urandom);
    build_ref();
    send_msg(1'b0, 11);
    in_valid = 1'b0;
    wait_outputs(15, 100);
    if (act_q.size() >= 15) check_cw(0, "after_reset");
  endtask

  initial begin
    build_tables();
    test_reset();
    test_all_zero();
    test_last_one();
    test_first_one();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
